ex_stage_muldiv: RTL and testbench
==================================

Name: ex_stage_muldiv

Overview:
Execute stage of the 5-stage MIPS pipeline. It consumes the ForwardA/ForwardB selects from the forwarding logic and applies them to the ID/EX operands. It executes single-cycle ALU ops and a 32-cycle iterative unsigned multiply/divide unit that writes the HI/LO registers. It drives the EX/MEM pipeline register and a stall back to IF/ID/ID-EX while the multiply/divide unit is busy.

Parameters:
MD_CYCLES, 32, iteration count of the multiply/divide datapath; fixed at 32 for a 32-bit datapath.

Ports:
clk  input  1  pipeline clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
ID_EX_valid  input  1  a real instruction is present in ID/EX
ID_EX_ALUCtrl  input  4  operation select (encoding below)
ID_EX_ALUSrc  input  1  1: operand B = ID_EX_imm; 0: forwarded rt
ID_EX_rs_data  input  32  register-file rs value
ID_EX_rt_data  input  32  register-file rt value
ID_EX_imm  input  32  sign/zero-extended immediate
ID_EX_RegWrite  input  1  instruction writes GPR
ID_EX_WriteReg  input  5  destination GPR
ForwardA  input  2  rs select: 00 reg, 10 EX/MEM, 01 MEM/WB, 11 treated as 00
ForwardB  input  2  rt select, same encoding
WB_WriteData  input  32  MEM/WB writeback value
EX_MEM_ALUResult  output  32  registered result; also the forwarding source
EX_MEM_StoreData  output  32  registered forwarded rt, never imm
EX_MEM_Zero  output  1  registered (result == 0)
EX_MEM_RegWrite  output  1  registered write enable
EX_MEM_WriteReg  output  5  registered destination
stall_ex  output  1  freeze PC, IF/ID and ID/EX this cycle
HI  output  32  HI register
LO  output  32  LO register

Behaviour:
- ALUCtrl encoding: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 0/1), 1100 NOR, 1000 MULTU, 1001 DIVU, 1010 MFHI, 1011 MFLO. Any other value gives result 0.
- ADD/SUB wrap modulo 2^32; no overflow trap.
- Operand A is the forwarded rs. Operand B is ID_EX_imm if ALUSrc=1, else the forwarded rt. The EX/MEM forward source is this block's own EX_MEM_ALUResult output.
- Single-cycle ops: result registered into EX/MEM at the next edge; latency 1.
- MD FSM states: IDLE, BUSY, DONE.
  - IDLE: if ID_EX_valid and op is MULTU/DIVU, issue. Operands are captured from the forwarded values in the issue cycle, the counter is cleared, and the FSM goes to BUSY. stall_ex=1 combinationally in the issue cycle.
  - BUSY: one shift-add (MULTU) or restoring-subtract (DIVU) step per cycle, stall_ex=1. After MD_CYCLES steps, HI/LO are written at that edge and the FSM goes to DONE.
  - DONE: stall_ex=0, with no re-issue even though the same instruction is still in ID/EX. The FSM returns to IDLE next cycle.
- Total stall: 33 cycles per MULTU/DIVU.
- MULTU: {HI,LO} = 64-bit unsigned product.
- DIVU: LO = quotient, HI = remainder. Divide by zero gives LO=32'hFFFFFFFF, HI=dividend, same latency, no exception.
- MULTU/DIVU have no GPR write. EX/MEM receives a bubble (RegWrite=0, result 0) in every cycle where stall_ex=1 and in the DONE cycle.
- ID_EX_valid=0 gives a bubble: RegWrite=0, WriteReg=0, result 0.
- MFHI/MFLO read the HI/LO registers. An MFHI/MFLO entering EX the cycle after DONE sees the new values.
- HI/LO change only on MD completion or reset.
- Reset (synchronous, any state, including mid-BUSY):
  - FSM to IDLE, counter 0, any in-flight operation discarded.
  - HI=LO=0.
  - All EX_MEM_* outputs 0.
  - stall_ex=0 in the cycle after the reset edge.

Test Plan:
- Forwarding: rs_data=1, EX_MEM_ALUResult=5 (previous op), ForwardA=10, ForwardB=01, WB_WriteData=3, ADD -> EX_MEM_ALUResult=8; repeat with ForwardA=11 -> uses rs_data, result 4.
- MULTU 0xFFFFFFFF*2 -> stall_ex high exactly 33 cycles, then HI=1, LO=0xFFFFFFFE; EX_MEM_RegWrite=0 throughout.
- DIVU 100/7 -> LO=14, HI=2 after 33 stall cycles; DIVU 9/0 -> LO=0xFFFFFFFF, HI=9.
- MULTU immediately followed by MFHI held in IF/ID -> no second issue in the DONE cycle; MFHI produces EX_MEM_ALUResult=HI with RegWrite=1.
- Assert reset at BUSY count 10 -> next cycle stall_ex=0, HI=LO=0, EX_MEM_* all 0; a fresh MULTU 3*4 then yields LO=12.
- SLT 0xFFFFFFFF vs 1 -> result 1, Zero=0; SUB 5-5 -> result 0, Zero=1.

Source files
------------

// File: rtl/ex_stage_muldiv_if.sv
// ex_stage_muldiv_if
// Bundles the ID/EX operand bus, forwarding selects, writeback data and
// the EX/MEM / HI / LO / stall outputs of the execute stage.
//   master : pipeline side (drives ID/EX, forwarding and writeback inputs)
//   slave  : execute stage (drives EX/MEM, stall_ex, HI, LO)
interface ex_stage_muldiv_if;
   logic        ID_EX_valid;
   logic [3:0]  ID_EX_ALUCtrl;
   logic        ID_EX_ALUSrc;
   logic [31:0] ID_EX_rs_data;
   logic [31:0] ID_EX_rt_data;
   logic [31:0] ID_EX_imm;
   logic        ID_EX_RegWrite;
   logic [4:0]  ID_EX_WriteReg;
   logic [1:0]  ForwardA;
   logic [1:0]  ForwardB;
   logic [31:0] WB_WriteData;
   logic [31:0] EX_MEM_ALUResult;
   logic [31:0] EX_MEM_StoreData;
   logic        EX_MEM_Zero;
   logic        EX_MEM_RegWrite;
   logic [4:0]  EX_MEM_WriteReg;
   logic        stall_ex;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (
      output ID_EX_valid, ID_EX_ALUCtrl, ID_EX_ALUSrc, ID_EX_rs_data, ID_EX_rt_data,
             ID_EX_imm, ID_EX_RegWrite, ID_EX_WriteReg, ForwardA, ForwardB, WB_WriteData,
      input  EX_MEM_ALUResult, EX_MEM_StoreData, EX_MEM_Zero, EX_MEM_RegWrite,
             EX_MEM_WriteReg, stall_ex, HI, LO
   );

   modport slave (
      input  ID_EX_valid, ID_EX_ALUCtrl, ID_EX_ALUSrc, ID_EX_rs_data, ID_EX_rt_data,
             ID_EX_imm, ID_EX_RegWrite, ID_EX_WriteReg, ForwardA, ForwardB, WB_WriteData,
      output EX_MEM_ALUResult, EX_MEM_StoreData, EX_MEM_Zero, EX_MEM_RegWrite,
             EX_MEM_WriteReg, stall_ex, HI, LO
   );
endinterface

// File: rtl/ex_stage_muldiv.sv
// ex_stage_muldiv
// MIPS execute stage: operand forwarding, single-cycle ALU, and a
// 32-step iterative unsigned multiply/divide unit writing HI/LO.
// Ports:
//   clk   : pipeline clock
//   reset : synchronous active-high reset
//   bus   : ex_stage_muldiv_if.slave (ID/EX in, EX/MEM + HI/LO + stall_ex out)
module ex_stage_muldiv #(
   parameter int MD_CYCLES = 32
) (
   input  logic               clk,
   input  logic               reset,
   ex_stage_muldiv_if.slave   bus
);
   localparam int CNT_W = $clog2(MD_CYCLES);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_SLT   = 4'b0111;
   localparam logic [3:0] OP_NOR   = 4'b1100;
   localparam logic [3:0] OP_MULTU = 4'b1000;
   localparam logic [3:0] OP_DIVU  = 4'b1001;
   localparam logic [3:0] OP_MFHI  = 4'b1010;
   localparam logic [3:0] OP_MFLO  = 4'b1011;

   logic [1:0]       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [31:0]      acc_hi_q, acc_lo_q, opd_q;
   logic             is_div_q;
   logic [31:0]      hi_q, lo_q;
   logic [31:0]      res_q, store_q;
   logic             zero_q, regwr_q;
   logic [4:0]       wreg_q;

   logic [31:0] op_a, fwd_b, op_b, alu_res;
   logic        is_md, issue, stall, bubble;
   logic [32:0] mul_sum, div_rem;
   logic [31:0] md_hi_nxt, md_lo_nxt;

   // Forwarding: 10 = EX/MEM (our own output), 01 = MEM/WB, 00/11 = register file
   always_comb begin
      op_a = bus.ID_EX_rs_data;
      case (bus.ForwardA)
         2'b10:   op_a = res_q;
         2'b01:   op_a = bus.WB_WriteData;
         default: op_a = bus.ID_EX_rs_data;
      endcase
      fwd_b = bus.ID_EX_rt_data;
      case (bus.ForwardB)
         2'b10:   fwd_b = res_q;
         2'b01:   fwd_b = bus.WB_WriteData;
         default: fwd_b = bus.ID_EX_rt_data;
      endcase
      op_b = bus.ID_EX_ALUSrc ? bus.ID_EX_imm : fwd_b;
   end

   always_comb begin
      alu_res = 32'd0;
      case (bus.ID_EX_ALUCtrl)
         OP_AND:  alu_res = op_a & op_b;
         OP_OR:   alu_res = op_a | op_b;
         OP_ADD:  alu_res = op_a + op_b;
         OP_SUB:  alu_res = op_a - op_b;
         OP_SLT:  alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
         OP_NOR:  alu_res = ~(op_a | op_b);
         OP_MFHI: alu_res = hi_q;
         OP_MFLO: alu_res = lo_q;
         default: alu_res = 32'd0;
      endcase
   end

   assign is_md = (bus.ID_EX_ALUCtrl == OP_MULTU) || (bus.ID_EX_ALUCtrl == OP_DIVU);
   // Only IDLE issues, so the instruction still sitting in ID/EX during DONE is ignored
   assign issue = (state_q == S_IDLE) && bus.ID_EX_valid && is_md;
   assign stall = issue || (state_q == S_BUSY);
   // MD ops themselves never write a GPR, so they always leave a bubble
   assign bubble = !bus.ID_EX_valid || stall || (state_q == S_DONE) || is_md;

   // One MD step. Multiply: {hi,lo} holds partial product / remaining multiplier,
   // add multiplicand into hi on lo[0] then shift right. Divide (restoring):
   // hi = remainder, lo = dividend shifting out / quotient shifting in.
   // A zero divisor naturally yields quotient all-ones and remainder = dividend.
   always_comb begin
      mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opd_q} : 33'd0);
      div_rem   = {acc_hi_q, acc_lo_q[31]};
      md_hi_nxt = mul_sum[32:1];
      md_lo_nxt = {mul_sum[0], acc_lo_q[31:1]};
      if (is_div_q) begin
         if (div_rem >= {1'b0, opd_q}) begin
            md_hi_nxt = 32'(div_rem - {1'b0, opd_q});
            md_lo_nxt = {acc_lo_q[30:0], 1'b1};
         end else begin
            md_hi_nxt = div_rem[31:0];
            md_lo_nxt = {acc_lo_q[30:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_hi_q <= 32'd0;
         acc_lo_q <= 32'd0;
         opd_q    <= 32'd0;
         is_div_q <= 1'b0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
      end else begin
         case (state_q)
            S_IDLE: if (issue) begin
               is_div_q <= (bus.ID_EX_ALUCtrl == OP_DIVU);
               acc_hi_q <= 32'd0;
               acc_lo_q <= (bus.ID_EX_ALUCtrl == OP_DIVU) ? op_a : op_b;
               opd_q    <= (bus.ID_EX_ALUCtrl == OP_DIVU) ? op_b : op_a;
               cnt_q    <= '0;
               state_q  <= S_BUSY;
            end
            S_BUSY: begin
               acc_hi_q <= md_hi_nxt;
               acc_lo_q <= md_lo_nxt;
               cnt_q    <= cnt_q + 1'b1;
               if (cnt_q == CNT_W'(MD_CYCLES - 1)) begin
                  hi_q    <= md_hi_nxt;
                  lo_q    <= md_lo_nxt;
                  state_q <= S_DONE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // EX/MEM register; a bubble is an all-zero packet, same as reset
   always_ff @(posedge clk) begin
      if (reset || bubble) begin
         res_q   <= 32'd0;
         store_q <= 32'd0;
         zero_q  <= 1'b0;
         regwr_q <= 1'b0;
         wreg_q  <= 5'd0;
      end else begin
         res_q   <= alu_res;
         store_q <= fwd_b;
         zero_q  <= (alu_res == 32'd0);
         regwr_q <= bus.ID_EX_RegWrite;
         wreg_q  <= bus.ID_EX_WriteReg;
      end
   end

   assign bus.EX_MEM_ALUResult = res_q;
   assign bus.EX_MEM_StoreData = store_q;
   assign bus.EX_MEM_Zero      = zero_q;
   assign bus.EX_MEM_RegWrite  = regwr_q;
   assign bus.EX_MEM_WriteReg  = wreg_q;
   assign bus.stall_ex         = stall;
   assign bus.HI               = hi_q;
   assign bus.LO               = lo_q;
endmodule

// File: tb/tb_ex_stage_muldiv.sv
module tb_ex_stage_muldiv;
   logic clk = 1'b0;
   logic reset;
   int   nchk = 0;
   int   nerr = 0;
   int   n;
   logic rw_seen;

   ex_stage_muldiv_if bus();

   ex_stage_muldiv #(.MD_CYCLES(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [3:0] ctrl, input logic src,
                        input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm,
                        input logic rw, input logic [4:0] wr,
                        input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] wb);
      bus.ID_EX_valid    = v;
      bus.ID_EX_ALUCtrl  = ctrl;
      bus.ID_EX_ALUSrc   = src;
      bus.ID_EX_rs_data  = rs;
      bus.ID_EX_rt_data  = rt;
      bus.ID_EX_imm      = imm;
      bus.ID_EX_RegWrite = rw;
      bus.ID_EX_WriteReg = wr;
      bus.ForwardA       = fa;
      bus.ForwardB       = fb;
      bus.WB_WriteData   = wb;
   endtask

   // Issue an MD op and hold it in ID/EX while stalled; returns in the DONE cycle
   task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int cnt, output logic rw);
      drive(1, op, 0, a, b, 0, 0, 0, 2'b00, 2'b00, 0);
      #1;
      cnt = 0;
      rw  = 1'b0;
      while (bus.stall_ex && cnt < 100) begin
         cnt++;
         if (bus.EX_MEM_RegWrite) rw = 1'b1;
         tick();
      end
      if (bus.EX_MEM_RegWrite) rw = 1'b1;
   endtask

   initial begin
      reset = 1'b1;
      drive(0, 4'b0000, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
      tick();
      tick();
      chk("rst_res",   bus.EX_MEM_ALUResult, 32'd0);
      chk("rst_store", bus.EX_MEM_StoreData, 32'd0);
      chk("rst_zero",  32'(bus.EX_MEM_Zero), 32'd0);
      chk("rst_rw",    32'(bus.EX_MEM_RegWrite), 32'd0);
      chk("rst_wreg",  32'(bus.EX_MEM_WriteReg), 32'd0);
      chk("rst_hi",    bus.HI, 32'd0);
      chk("rst_lo",    bus.LO, 32'd0);
      reset = 1'b0;
      #1;
      chk("rst_stall", 32'(bus.stall_ex), 32'd0);

      // ADD 2 + imm 3 -> 5 establishes the EX/MEM forward source
      drive(1, 4'b0010, 1, 32'd2, 32'd0, 32'd3, 1, 5'd5, 2'b00, 2'b00, 0);
      tick();
      chk("add_imm",  bus.EX_MEM_ALUResult, 32'd5);
      chk("add_rw",   32'(bus.EX_MEM_RegWrite), 32'd1);
      chk("add_wreg", 32'(bus.EX_MEM_WriteReg), 32'd5);
      // A from EX/MEM (5), B from WB (3) -> 8
      drive(1, 4'b0010, 0, 32'd1, 32'h77, 32'd0, 1, 5'd6, 2'b10, 2'b01, 32'd3);
      tick();
      chk("fwd_exmem", bus.EX_MEM_ALUResult, 32'd8);
      chk("fwd_store", bus.EX_MEM_StoreData, 32'd3);
      // ForwardA=11 falls back to rs_data (1) -> 1+3
      bus.ForwardA = 2'b11;
      tick();
      chk("fwd_11", bus.EX_MEM_ALUResult, 32'd4);

      drive(1, 4'b0111, 0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 5'd7, 2'b00, 2'b00, 0);
      tick();
      chk("slt_res",  bus.EX_MEM_ALUResult, 32'd1);
      chk("slt_zero", 32'(bus.EX_MEM_Zero), 32'd0);
      drive(1, 4'b0110, 0, 32'd5, 32'd5, 32'd0, 1, 5'd7, 2'b00, 2'b00, 0);
      tick();
      chk("sub_res",  bus.EX_MEM_ALUResult, 32'd0);
      chk("sub_zero", 32'(bus.EX_MEM_Zero), 32'd1);
      drive(1, 4'b1100, 0, 32'h0F0F_0000, 32'h0000_00F0, 32'd0, 1, 5'd7, 2'b00, 2'b00, 0);
      tick();
      chk("nor_res", bus.EX_MEM_ALUResult, 32'hF0F0_FF0F);
      drive(1, 4'b0011, 0, 32'd5, 32'd6, 32'd0, 1, 5'd7, 2'b00, 2'b00, 0);
      tick();
      chk("undef_op", bus.EX_MEM_ALUResult, 32'd0);
      drive(0, 4'b0010, 0, 32'd5, 32'd6, 32'd0, 1, 5'd9, 2'b00, 2'b00, 0);
      tick();
      chk("invalid_rw",   32'(bus.EX_MEM_RegWrite), 32'd0);
      chk("invalid_wreg", 32'(bus.EX_MEM_WriteReg), 32'd0);

      // MULTU 0xFFFFFFFF * 2
      run_md(4'b1000, 32'hFFFF_FFFF, 32'd2, n, rw_seen);
      chk("mul_stall_cnt", 32'(n), 32'd33);
      chk("mul_rw",        32'(rw_seen), 32'd0);
      chk("mul_hi",        bus.HI, 32'd1);
      chk("mul_lo",        bus.LO, 32'hFFFF_FFFE);
      // DONE cycle passes with MULTU still in ID/EX; MFHI follows
      tick();
      drive(1, 4'b1010, 0, 32'd0, 32'd0, 32'd0, 1, 5'd9, 2'b00, 2'b00, 0);
      #1;
      chk("no_reissue", 32'(bus.stall_ex), 32'd0);
      chk("done_bubble_rw", 32'(bus.EX_MEM_RegWrite), 32'd0);
      tick();
      chk("mfhi_res",  bus.EX_MEM_ALUResult, 32'd1);
      chk("mfhi_rw",   32'(bus.EX_MEM_RegWrite), 32'd1);
      chk("mfhi_wreg", 32'(bus.EX_MEM_WriteReg), 32'd9);
      bus.ID_EX_ALUCtrl = 4'b1011;
      tick();
      chk("mflo_res", bus.EX_MEM_ALUResult, 32'hFFFF_FFFE);

      // DIVU 100 / 7
      run_md(4'b1001, 32'd100, 32'd7, n, rw_seen);
      chk("div_stall_cnt", 32'(n), 32'd33);
      chk("div_lo", bus.LO, 32'd14);
      chk("div_hi", bus.HI, 32'd2);
      bus.ID_EX_valid = 1'b0;
      tick();
      // DIVU 9 / 0
      run_md(4'b1001, 32'd9, 32'd0, n, rw_seen);
      chk("div0_stall_cnt", 32'(n), 32'd33);
      chk("div0_lo", bus.LO, 32'hFFFF_FFFF);
      chk("div0_hi", bus.HI, 32'd9);
      bus.ID_EX_valid = 1'b0;
      tick();

      // Reset in the middle of BUSY (after 10 steps)
      drive(1, 4'b1000, 0, 32'd3, 32'd4, 32'd0, 0, 0, 2'b00, 2'b00, 0);
      for (int i = 0; i < 11; i++) tick();
      chk("busy_stall", 32'(bus.stall_ex), 32'd1);
      reset = 1'b1;
      bus.ID_EX_valid = 1'b0;
      tick();
      reset = 1'b0;
      #1;
      chk("mid_rst_stall", 32'(bus.stall_ex), 32'd0);
      chk("mid_rst_hi",    bus.HI, 32'd0);
      chk("mid_rst_lo",    bus.LO, 32'd0);
      chk("mid_rst_res",   bus.EX_MEM_ALUResult, 32'd0);
      chk("mid_rst_rw",    32'(bus.EX_MEM_RegWrite), 32'd0);
      chk("mid_rst_wreg",  32'(bus.EX_MEM_WriteReg), 32'd0);
      run_md(4'b1000, 32'd3, 32'd4, n, rw_seen);
      chk("mul2_stall_cnt", 32'(n), 32'd33);
      chk("mul2_lo", bus.LO, 32'd12);
      chk("mul2_hi", bus.HI, 32'd0);
      bus.ID_EX_valid = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end
endmodule
